// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the datapath and the stall/flush sequencer.
// With HAZ_PERF_EN defined the bundle also carries the stall/flush perf counters.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
`ifdef HAZ_PERF_EN
  , parameter int CNT_W = 32
`endif
);
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             ex_MemtoReg;
  logic [REG_W-1:0] ex_rw;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             branch_taken;
  logic             halt_ex;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic [2:0]       state_o;
`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  // The datapath side drives hazard status and consumes latch controls.
  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_MemtoReg, ex_rw, id_rs, id_rt,
           branch_taken, halt_ex,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt, state_o
`ifdef HAZ_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_MemtoReg, ex_rw, id_rs, id_rt,
           branch_taken, halt_ex,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt, state_o
`ifdef HAZ_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: dcache waits, load-use bubbles,
// branch flushes, icache misses and halt drain. HAZ_PERF_EN adds perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 2
`ifdef HAZ_PERF_EN
  , parameter int CNT_W      = 32
`endif
) (
  input logic                   CLK,
  input logic                   nRST,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] MEMWAIT = 3'd1;
  localparam logic [2:0] LDSTALL = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] HALTED  = 3'd4;
  localparam int DC_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [2:0]      state, stateNext;
  logic [DC_W-1:0] drainCnt, drainCntNext, drainDec;
  logic            fromDrain, fromDrainNext;
  logic            memWait, loadUse, drainDone, frozen, killAll;
  logic            pcEn, ifidEn, ifidFlush, idexEn, idexFlush;
  logic            exmemEn, exmemFlush, memwbEn, memwbFlush;

  assign memWait   = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
  assign loadUse   = hz.ex_MemtoReg && (hz.ex_rw != REG_W'(0)) &&
                     ((hz.ex_rw == hz.id_rs) || (hz.ex_rw == hz.id_rt));
  assign drainDone = (drainCnt <= DC_W'(1));
  assign drainDec  = drainDone ? '0 : drainCnt - DC_W'(1);
  assign killAll   = !nRST || (state == HALTED);

  // Priority-ordered hazard resolution; frozen/killAll overlays are applied last.
  always_comb begin
    stateNext     = state;
    drainCntNext  = drainCnt;
    fromDrainNext = fromDrain;
    frozen        = 1'b0;
    pcEn          = 1'b1;
    ifidEn        = 1'b1;
    ifidFlush     = 1'b0;
    idexEn        = 1'b1;
    idexFlush     = 1'b0;
    exmemEn       = 1'b1;
    exmemFlush    = 1'b0;
    memwbEn       = 1'b1;
    memwbFlush    = 1'b0;
    case (state)
      RUN, LDSTALL: begin
        stateNext = RUN;
        if (memWait) begin
          frozen        = 1'b1;
          stateNext     = MEMWAIT;
          fromDrainNext = 1'b0;
        end else if (hz.branch_taken) begin
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
        end else if ((state == RUN) && hz.halt_ex) begin
          pcEn         = 1'b0;
          ifidFlush    = 1'b1;
          idexFlush    = 1'b1;
          drainCntNext = DC_W'(DRAIN_CYCLES);
          stateNext    = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
        end else if ((state == RUN) && loadUse) begin
          pcEn      = 1'b0;
          ifidEn    = 1'b0;
          idexFlush = 1'b1;
          stateNext = LDSTALL;
        end else if (!hz.ihit) begin
          pcEn      = 1'b0;
          ifidFlush = 1'b1;
        end
      end
      MEMWAIT: begin
        // The dhit cycle advances the pipe, so it also counts toward the drain.
        if (!hz.dhit) begin
          frozen = 1'b1;
        end else if (fromDrain) begin
          drainCntNext = drainDec;
          stateNext    = drainDone ? HALTED : DRAIN;
        end else begin
          stateNext = RUN;
        end
      end
      DRAIN: begin
        if (memWait) begin
          frozen        = 1'b1;
          stateNext     = MEMWAIT;
          fromDrainNext = 1'b1;
        end else begin
          pcEn         = 1'b0;
          ifidFlush    = 1'b1;
          idexFlush    = 1'b1;
          drainCntNext = drainDec;
          stateNext    = drainDone ? HALTED : DRAIN;
        end
      end
      HALTED: stateNext = HALTED;
      default: begin
        frozen    = 1'b1;
        stateNext = RUN;
      end
    endcase
    if (frozen || killAll) begin
      pcEn    = 1'b0;
      ifidEn  = 1'b0;
      idexEn  = 1'b0;
      exmemEn = 1'b0;
      memwbEn = 1'b0;
    end
    if (killAll) begin
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
      memwbFlush = 1'b1;
    end
  end

  // Sequencer state; reset abandons any stall or drain in progress.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drainCnt  <= '0;
      fromDrain <= 1'b0;
    end else begin
      state     <= stateNext;
      drainCnt  <= drainCntNext;
      fromDrain <= fromDrainNext;
    end
  end

  assign hz.pc_en       = pcEn;
  assign hz.ifid_en     = ifidEn;
  assign hz.ifid_flush  = ifidFlush;
  assign hz.idex_en     = idexEn;
  assign hz.idex_flush  = idexFlush;
  assign hz.exmem_en    = exmemEn;
  assign hz.exmem_flush = exmemFlush;
  assign hz.memwb_en    = memwbEn;
  assign hz.memwb_flush = memwbFlush;
  assign hz.halt        = nRST && (state == HALTED);
  assign hz.state_o     = state;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic             flushEvent;

  assign flushEvent = ((state == RUN) || (state == LDSTALL)) && !memWait && hz.branch_taken;

  // Saturating counters of lost fetch cycles and branch flushes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcEn && (state != HALTED) && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if (flushEvent && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a flag-based hazard model checked every cycle
// plus directed vectors with literal expectations. HAZ_PERF_EN enables counter checks.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W        = 5;
  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 32;

  // Output vector: {halt, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //                 exmem_en, exmem_flush, memwb_en, memwb_flush}
  localparam logic [9:0] O_DEF    = 10'b0_1_10_10_10_10;
  localparam logic [9:0] O_FREEZE = 10'b0_0_00_00_00_00;
  localparam logic [9:0] O_RESET  = 10'b0_0_01_01_01_01;
  localparam logic [9:0] O_HALT   = 10'b1_0_01_01_01_01;
  localparam logic [9:0] O_BRANCH = 10'b0_1_11_11_10_10;
  localparam logic [9:0] O_DRAIN  = 10'b0_0_11_11_10_10;
  localparam logic [9:0] O_LDUSE  = 10'b0_0_00_11_10_10;
  localparam logic [9:0] O_IMISS  = 10'b0_0_11_10_10_10;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       dREN;
    logic       dWEN;
    logic       exLoad;
    logic [4:0] exRw;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       br;
    logic       haltEx;
  } stim_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bit mHalted = 0, mWait = 0, mBubble = 0, mDraining = 0;
  int mLeft = 0;
  bit nHalted = 0, nWait = 0, nBubble = 0, nDraining = 0;
  int nLeft = 0;
  logic [CNT_W-1:0] mStall = '0, mFlush = '0, nStall = '0, nFlush = '0;

`ifdef HAZ_PERF_EN
  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();
  pipeline_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .hz(hz));
`else
  pipeline_hazard_ctrl_if #(.REG_W(REG_W)) hz ();
  pipeline_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .CLK(CLK), .nRST(nRST), .hz(hz));
`endif

  always #5 CLK = ~CLK;

  function automatic logic [9:0] dutOut();
    return {hz.halt, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
            hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.memwb_flush};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s      = '0;
    s.ihit = 1'b1;
    s.dhit = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    hz.ihit         = s.ihit;
    hz.dhit         = s.dhit;
    hz.mem_dREN     = s.dREN;
    hz.mem_dWEN     = s.dWEN;
    hz.ex_MemtoReg  = s.exLoad;
    hz.ex_rw        = s.exRw;
    hz.id_rs        = s.idRs;
    hz.id_rt        = s.idRt;
    hz.branch_taken = s.br;
    hz.halt_ex      = s.haltEx;
  endtask

  // Reference behaviour: what the pipeline must see this cycle given pending hazards.
  task automatic modelEval(output logic [9:0] o, output logic [2:0] st);
    bit memStall, ldHazard, wasBubble;
    memStall  = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
    ldHazard  = hz.ex_MemtoReg && (hz.ex_rw != 0) &&
                ((hz.ex_rw == hz.id_rs) || (hz.ex_rw == hz.id_rt));
    nHalted   = mHalted;
    nWait     = mWait;
    nBubble   = 0;
    nDraining = mDraining;
    nLeft     = mLeft;
    nStall    = mStall;
    nFlush    = mFlush;
    if (!nRST) begin
      o  = O_RESET;
      st = 3'd0;
    end else if (mHalted) begin
      o  = O_HALT;
      st = 3'd4;
    end else if (mWait) begin
      st = 3'd1;
      if (!hz.dhit) o = O_FREEZE;
      else begin
        o     = O_DEF;
        nWait = 0;
        if (mDraining) begin
          nLeft = mLeft - 1;
          if (nLeft <= 0) begin nDraining = 0; nHalted = 1; end
        end
      end
    end else if (mDraining) begin
      st = 3'd3;
      if (memStall) begin
        o     = O_FREEZE;
        nWait = 1;
      end else begin
        o     = O_DRAIN;
        nLeft = mLeft - 1;
        if (nLeft <= 0) begin nDraining = 0; nHalted = 1; end
      end
    end else begin
      wasBubble = mBubble;
      st = wasBubble ? 3'd2 : 3'd0;
      if (memStall) begin
        o     = O_FREEZE;
        nWait = 1;
      end else if (hz.branch_taken) begin
        o = O_BRANCH;
        if (mFlush != '1) nFlush = mFlush + 1;
      end else if (!wasBubble && hz.halt_ex) begin
        o         = O_DRAIN;
        nDraining = 1;
        nLeft     = DRAIN_CYCLES;
        if (nLeft == 0) begin nDraining = 0; nHalted = 1; end
      end else if (!wasBubble && ldHazard) begin
        o       = O_LDUSE;
        nBubble = 1;
      end else if (!hz.ihit) o = O_IMISS;
      else o = O_DEF;
    end
    if (nRST && !mHalted && !o[8] && (mStall != '1)) nStall = mStall + 1;
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mHalted <= 0; mWait <= 0; mBubble <= 0; mDraining <= 0; mLeft <= 0;
      mStall <= '0; mFlush <= '0;
    end else begin
      mHalted <= nHalted; mWait <= nWait; mBubble <= nBubble; mDraining <= nDraining;
      mLeft <= nLeft; mStall <= nStall; mFlush <= nFlush;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge CLK) begin
    logic [9:0] expO;
    logic [2:0] expS;
    modelEval(expO, expS);
    checks++;
    if (dutOut() !== expO) begin
      failures++;
      $display("[TB] FAIL model_outputs t=%0t actual=%b required=%b", $time, dutOut(), expO);
    end
    checks++;
    if (hz.state_o !== expS) begin
      failures++;
      $display("[TB] FAIL model_state t=%0t actual=%0d required=%0d", $time, hz.state_o, expS);
    end
`ifdef HAZ_PERF_EN
    checks++;
    if ({hz.stall_cnt, hz.flush_cnt} !== {mStall, mFlush}) begin
      failures++;
      $display("[TB] FAIL model_perf t=%0t actual=%0d/%0d required=%0d/%0d", $time,
               hz.stall_cnt, hz.flush_cnt, mStall, mFlush);
    end
`endif
  end

  task automatic checkOutput(input string name, input logic [9:0] expO, input logic [2:0] expS);
    checks++;
    if ({dutOut(), hz.state_o} !== {expO, expS}) begin
      failures++;
      $display("[TB] FAIL %s actual=%b/%0d required=%b/%0d", name, dutOut(), hz.state_o,
               expO, expS);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      drive(s);
      @(negedge CLK);
    end
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    drive(idle());
    @(negedge CLK);
    checkOutput("reset_outputs", O_RESET, 3'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("idle_after_reset", O_DEF, 3'd0);
  endtask

  initial begin
    stim_t s;
    drive(idle());
    repeat (2) @(negedge CLK);
    checkOutput("power_on_reset", O_RESET, 3'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("first_run_cycle", O_DEF, 3'd0);

    // Load-use on rs, then on rt; ex_rw==0 never stalls.
    s = idle(); s.exLoad = 1; s.exRw = 5'd3; s.idRs = 5'd3;
    applyStimulus(s, 1);
    checkOutput("loaduse_rs", O_LDUSE, 3'd0);
    applyStimulus(idle(), 1);
    checkOutput("loaduse_bubble", O_DEF, 3'd2);
    applyStimulus(idle(), 1);
    checkOutput("loaduse_resume", O_DEF, 3'd0);
    s = idle(); s.exLoad = 1; s.exRw = 5'd0; s.idRs = 5'd0; s.idRt = 5'd0;
    applyStimulus(s, 1);
    checkOutput("loaduse_r0", O_DEF, 3'd0);
    s = idle(); s.exLoad = 1; s.exRw = 5'd7; s.idRs = 5'd2; s.idRt = 5'd7;
    applyStimulus(s, 1);
    checkOutput("loaduse_rt", O_LDUSE, 3'd0);
    applyStimulus(idle(), 1);
    checkOutput("loaduse_rt_bubble", O_DEF, 3'd2);

    // Load waiting three cycles on the dcache.
    s = idle(); s.dREN = 1; s.dhit = 0;
    applyStimulus(s, 1);
    checkOutput("memwait_enter", O_FREEZE, 3'd0);
    applyStimulus(s, 1);
    checkOutput("memwait_hold1", O_FREEZE, 3'd1);
    applyStimulus(s, 1);
    checkOutput("memwait_hold2", O_FREEZE, 3'd1);
    s.dhit = 1;
    applyStimulus(s, 1);
    checkOutput("memwait_dhit", O_DEF, 3'd1);
    applyStimulus(idle(), 1);
    checkOutput("memwait_exit", O_DEF, 3'd0);

    // Store wait of one cycle.
    s = idle(); s.dWEN = 1; s.dhit = 0;
    applyStimulus(s, 1);
    checkOutput("store_wait", O_FREEZE, 3'd0);
    s.dhit = 1;
    applyStimulus(s, 1);
    checkOutput("store_dhit", O_DEF, 3'd1);

    // Branch overrides load-use and icache miss in the same cycle.
    s = idle(); s.br = 1; s.exLoad = 1; s.exRw = 5'd4; s.idRs = 5'd4; s.ihit = 0;
    applyStimulus(s, 1);
    checkOutput("branch_priority", O_BRANCH, 3'd0);
    applyStimulus(idle(), 1);
    checkOutput("branch_no_bubble", O_DEF, 3'd0);
    s = idle(); s.ihit = 0;
    applyStimulus(s, 2);
    checkOutput("imiss", O_IMISS, 3'd0);

    // Reset in the middle of a dcache wait.
    s = idle(); s.dREN = 1; s.dhit = 0;
    applyStimulus(s, 2);
    checkOutput("pre_reset_wait", O_FREEZE, 3'd1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("async_reset_in_wait", O_RESET, 3'd0);
    @(posedge CLK);
    #1;
    drive(idle());
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("run_after_reset", O_DEF, 3'd0);

    // Halt drain interrupted by one dcache wait cycle: halt four cycles later.
    s = idle(); s.haltEx = 1;
    applyStimulus(s, 1);
    checkOutput("halt_ex", O_DRAIN, 3'd0);
    s = idle(); s.dREN = 1; s.dhit = 0;
    applyStimulus(s, 1);
    checkOutput("drain_memwait", O_FREEZE, 3'd3);
    s.dhit = 1;
    applyStimulus(s, 1);
    checkOutput("drain_dhit", O_DEF, 3'd1);
    s = idle(); s.br = 1; s.ihit = 0;
    applyStimulus(s, 1);
    checkOutput("drain_ignores_branch", O_DRAIN, 3'd3);
    applyStimulus(s, 1);
    checkOutput("halted", O_HALT, 3'd4);
    s = idle(); s.haltEx = 1; s.dREN = 1; s.dhit = 0;
    applyStimulus(s, 2);
    checkOutput("halted_sticky", O_HALT, 3'd4);

    // Plain drain: halt three cycles after halt_ex.
    doReset();
    s = idle(); s.haltEx = 1;
    applyStimulus(s, 1);
    applyStimulus(idle(), 1);
    checkOutput("drain_1", O_DRAIN, 3'd3);
    applyStimulus(idle(), 1);
    checkOutput("drain_2", O_DRAIN, 3'd3);
    applyStimulus(idle(), 1);
    checkOutput("halted_plain", O_HALT, 3'd4);

`ifdef HAZ_PERF_EN
    doReset();
    s = idle(); s.br = 1;
    applyStimulus(s, 2);
    s = idle(); s.ihit = 0;
    applyStimulus(s, 3);
    applyStimulus(idle(), 1);
    checks++;
    if ({hz.flush_cnt, hz.stall_cnt} !== {32'd2, 32'd3}) begin
      failures++;
      $display("[TB] FAIL perf_counts actual=%0d/%0d required=2/3", hz.flush_cnt, hz.stall_cnt);
    end
`endif

    doReset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
